// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// led_pattern_gen : prescaled LED pattern generator (count, scan, breathe)
// Rev 1.0
// ============================================================================
module led_pattern_gen #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 20,
  parameter int PWM_W   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RUN,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] D,
  output logic             TICK,
  output logic             CLK_EN
);

  localparam int POS_W = $clog2(WIDTH);

  localparam logic [1:0] c_MODE_DOWN = 2'b00;
  localparam logic [1:0] c_MODE_UP   = 2'b01;
  localparam logic [1:0] c_MODE_SCAN = 2'b10;

  localparam logic [POS_W-1:0] c_POS_MAX  = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] c_POS_TURN = POS_W'(WIDTH - 2);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PRESC_W-1:0] r_presc;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   r_cnt;
  logic [POS_W-1:0]   r_pos;
  dir_t               r_dir;
  logic [PWM_W-1:0]   r_duty;
  dir_t               r_duty_dir;
  logic [PWM_W-1:0]   r_phase;

  logic             w_tick;
  logic             w_mode_chg;
  logic             w_pwm_on;
  logic [WIDTH-1:0] w_d_next;

  assign w_tick     = RUN && (r_presc == '1);
  assign w_mode_chg = (r_mode != MODE);
  assign w_pwm_on   = (r_phase < r_duty);

  always_comb begin
    w_d_next = '0;
    case (r_mode)
      c_MODE_DOWN, c_MODE_UP: w_d_next = r_cnt;
      c_MODE_SCAN:            w_d_next[r_pos] = 1'b1;
      default:                w_d_next = {WIDTH{w_pwm_on}};
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc    <= '0;
      r_mode     <= c_MODE_DOWN;
      r_cnt      <= '0;
      r_pos      <= '0;
      r_dir      <= DIR_UP;
      r_duty     <= '0;
      r_duty_dir <= DIR_UP;
      r_phase    <= '0;
      D          <= '0;
      TICK       <= 1'b0;
      CLK_EN     <= 1'b0;
    end else begin
      CLK_EN <= 1'b1;
      TICK   <= w_tick;
      r_mode <= MODE;
      D      <= w_d_next;
      if (RUN) begin
        r_presc <= r_presc + PRESC_W'(1);
      end

      // A mode switch restarts the pattern and swallows a coincident tick.
      if (w_mode_chg) begin
        r_cnt      <= '0;
        r_pos      <= '0;
        r_dir      <= DIR_UP;
        r_duty     <= '0;
        r_duty_dir <= DIR_UP;
        r_phase    <= '0;
      end else begin
        if (RUN) begin
          r_phase <= r_phase + PWM_W'(1);
        end
        if (w_tick) begin
          case (r_mode)
            c_MODE_DOWN: r_cnt <= r_cnt - WIDTH'(1);
            c_MODE_UP:   r_cnt <= r_cnt + WIDTH'(1);
            c_MODE_SCAN: begin
              if (r_dir == DIR_UP) begin
                if (r_pos == c_POS_MAX) begin
                  r_pos <= c_POS_TURN;
                  r_dir <= DIR_DOWN;
                end else begin
                  r_pos <= r_pos + POS_W'(1);
                end
              end else begin
                if (r_pos == '0) begin
                  r_pos <= POS_W'(1);
                  r_dir <= DIR_UP;
                end else begin
                  r_pos <= r_pos - POS_W'(1);
                end
              end
            end
            default: begin
              if (r_duty_dir == DIR_UP) begin
                if (r_duty == '1) begin
                  r_duty     <= r_duty - PWM_W'(1);
                  r_duty_dir <= DIR_DOWN;
                end else begin
                  r_duty <= r_duty + PWM_W'(1);
                end
              end else begin
                if (r_duty == '0) begin
                  r_duty     <= PWM_W'(1);
                  r_duty_dir <= DIR_UP;
                end else begin
                  r_duty <= r_duty - PWM_W'(1);
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// Bench for led_pattern_gen: randomized run/mode/reset stimulus, queue scoreboard
// against a tick-count reference model (triangle-wave arithmetic for scan/breathe).
module tb_led_pattern_gen;

  localparam int WIDTH   = 4;
  localparam int PRESC_W = 2;
  localparam int PWM_W   = 2;
  localparam int PRESC_N = 1 << PRESC_W;
  localparam int PHASE_N = 1 << PWM_W;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             tick;
  logic             clk_en;

  led_pattern_gen #(
    .WIDTH  (WIDTH),
    .PRESC_W(PRESC_W),
    .PWM_W  (PWM_W)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .RUN   (run),
    .MODE  (mode),
    .D     (d),
    .TICK  (tick),
    .CLK_EN(clk_en)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             tick;
    logic             en;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: ticks since the last pattern restart plus free-running counters.
  int               m_p;
  int               m_k;
  int               m_phase;
  logic [1:0]       m_mode;
  logic [WIDTH-1:0] m_d;
  logic             m_tick;
  logic             m_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pattern(input int k, input int ph, input logic [1:0] md);
    int n, m, pos, duty, top;
    n   = 1 << WIDTH;
    top = PHASE_N - 1;
    case (md)
      2'b00: return WIDTH'((n - (k % n)) % n);
      2'b01: return WIDTH'(k % n);
      2'b10: begin
        m   = k % (2 * (WIDTH - 1));
        pos = (m <= WIDTH - 1) ? m : 2 * (WIDTH - 1) - m;
        return WIDTH'(1) << pos;
      end
      default: begin
        m    = k % (2 * top);
        duty = (m <= top) ? m : 2 * top - m;
        return (ph < duty) ? '1 : '0;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_p = 0; m_k = 0; m_phase = 0; m_mode = 2'b00;
    m_d = '0; m_tick = 1'b0; m_en = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit [1:0] md);
    bit t;
    t      = r && (m_p == PRESC_N - 1);
    m_d    = pattern(m_k, m_phase, m_mode);
    m_tick = t;
    m_en   = 1'b1;
    if (r) m_p = (m_p + 1) % PRESC_N;
    if (md != m_mode) begin
      m_k = 0;
      m_phase = 0;
    end else begin
      if (r) m_phase = (m_phase + 1) % PHASE_N;
      if (t) m_k = m_k + 1;
    end
    m_mode = md;
  endtask

  task automatic push_exp();
    exp_t e;
    e.d = m_d; e.tick = m_tick; e.en = m_en;
    q.push_back(e);
  endtask

  // One clock of stimulus; pulse = reset glitch entirely inside the low phase.
  task automatic drive_cycle(input bit r, input bit [1:0] md, input bit pulse, input bit hold);
    @(negedge clk);
    #1;
    run  = r;
    mode = md;
    if (hold) begin
      rst_n = 1'b0;
      model_reset();
      push_exp();
      return;
    end
    if (pulse) begin
      rst_n = 1'b0;
      #1;
      vectors++;
      if (d !== '0 || tick !== 1'b0 || clk_en !== 1'b0) begin
        miscompares++;
        $display("FAIL async_reset: got D=%b TICK=%b CLK_EN=%b, want D=0000 TICK=0 CLK_EN=0",
                 d, tick, clk_en);
      end
      model_reset();
      rst_n = 1'b1;
      #1;
    end else begin
      rst_n = 1'b1;
    end
    model_step(r, md);
    push_exp();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (d !== e.d || tick !== e.tick || clk_en !== e.en) begin
        miscompares++;
        $display("FAIL outputs @%0t: got D=%b TICK=%b CLK_EN=%b, want D=%b TICK=%b CLK_EN=%b",
                 $time, d, tick, clk_en, e.d, e.tick, e.en);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion before %0t", $time);
    $fatal(1);
  end

  initial begin
    bit [1:0] rm;
    rst_n = 1'b0;
    run   = 1'b0;
    mode  = 2'b00;
    model_reset();

    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 70; i++) drive_cycle(1'b1, 2'b01, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 72; i++) drive_cycle(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive_cycle(1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) drive_cycle(1'b1, 2'b11, 1'b0, 1'b0);

    // Freeze mid-scan, then resume.
    for (int i = 0; i < 13; i++) drive_cycle(1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 2'b10, 1'b0, 1'b0);

    // Mode change landing on a tick, then a reset glitch mid-pattern.
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 4 && m_p != PRESC_N - 1; i++) drive_cycle(1'b1, 2'b01, 1'b0, 1'b0);
    drive_cycle(1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) drive_cycle(1'b1, 2'b10, 1'b0, 1'b0);
    drive_cycle(1'b1, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) drive_cycle(1'b1, 2'b10, 1'b0, 1'b0);

    rm = 2'b11;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) rm = 2'($urandom_range(0, 3));
      drive_cycle(($urandom_range(0, 7) != 0), rm, ($urandom_range(0, 299) == 0), 1'b0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8: number of LED outputs; WIDTH >= 2 SHALL be supported.
REQ-002 Parameter PRESC_W, default 20: prescaler width; tick period SHALL be 2^PRESC_W cycles; PRESC_W >= 1.
REQ-003 Parameter PWM_W, default 8: breathe duty/phase width; PWM_W >= 2.
REQ-004 CLK  in  1  single clock, all logic on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 RUN  in  1  1 = prescaler, PWM phase and pattern advance; 0 = all hold.
REQ-007 MODE  in  2  00 count-down, 01 count-up, 10 bounce-scan, 11 breathe.
REQ-008 D  out  WIDTH  registered LED pattern.
REQ-009 TICK  out  1  registered one-cycle pulse per prescaler wrap.
REQ-010 CLK_EN  out  1  registered oscillator enable.

Function
REQ-011 Prescaler: PRESC_W-bit counter SHALL increment by 1 each cycle RUN=1, wrap all-ones -> 0, hold when RUN=0.
REQ-012 Internal tick SHALL be true in the cycle the prescaler equals all-ones and RUN=1; TICK SHALL show it one cycle later.
REQ-013 Pattern state SHALL change only on internal tick, except on mode change (REQ-019).
REQ-014 Mode 00: WIDTH-bit counter CNT SHALL decrement mod 2^WIDTH per tick (0 -> all-ones); D = CNT.
REQ-015 Mode 01: CNT SHALL increment mod 2^WIDTH per tick (all-ones -> 0); D = CNT.
REQ-016 Mode 10: position POS (0..WIDTH-1) and DIR (up/down); D = one-hot bit POS; per tick, up: POS+1, at WIDTH-1 DIR becomes down and POS -> WIDTH-2; down: POS-1, at 0 DIR becomes up and POS -> 1; no end bit held two ticks.
REQ-017 Mode 11: DUTY (PWM_W bits) per tick SHALL step +1 while rising, -1 while falling; at all-ones reverse to falling (next DUTY = max-1); at 0 reverse to rising (next 1).
REQ-018 Mode 11: PWM_W-bit PHASE SHALL increment every RUN=1 cycle, wrapping; every D bit = (PHASE < DUTY); DUTY=0 -> D all 0.
REQ-019 MODE SHALL be registered each cycle; when registered MODE differs from input MODE, next cycle CNT=0, POS=0, DIR=up, DUTY=0 rising, PHASE=0; prescaler unaffected; a tick coinciding with a mode change SHALL be ignored for the pattern.
REQ-020 D SHALL be registered from current pattern state, latency 1 cycle after state update.
REQ-021 RUN=0 SHALL freeze D at its last value; RUN 0->1 SHALL resume from held state without skipping a tick.
REQ-022 CLK_EN SHALL be 1 from the first rising edge after RST_N deasserts and stay 1.

Reset
REQ-023 RST_N=0 SHALL immediately force D=0, TICK=0, CLK_EN=0, prescaler=0, CNT=0, POS=0, DIR=up, DUTY=0 rising, PHASE=0, registered MODE=00.
REQ-024 Reset asserted mid-pattern SHALL discard state; after release behaviour SHALL be identical to power-on.

Verification (WIDTH=4, PRESC_W=2, PWM_W=2 unless stated)
REQ-025 Reset release, RUN=1, MODE=01 -> CLK_EN=1 after first edge; TICK pulses every 4 cycles; D = 1,2,...,15,0 across 16 ticks.
REQ-026 MODE=00 from reset -> D sequence after ticks: 15,14,...,0,15 (wrap-around checked).
REQ-027 MODE=10 -> D one-hot sequence 0001,0010,0100,1000,0100,0010,0001,0010 on successive ticks.
REQ-028 MODE=11 -> DUTY ticks 0,1,2,3,2,1,0,1; with DUTY=2, D=1111 for PHASE 0,1 and 0000 for PHASE 2,3; DUTY=0 gives D=0000 constantly.
REQ-029 RUN=0 for 10 cycles mid-scan -> D, TICK spacing and prescaler frozen; resumes with next tick exactly 4 RUN=1 cycles after last.
REQ-030 MODE 01->10 change in same cycle as tick, then RST_N pulse mid-pattern -> pattern restarts at 0001 with tick ignored; reset forces D=0, CLK_EN=0 asynchronously.
